// File: rtl/fifo_stream_packer.sv
// Packs Ratio consecutive narrow words from fifo_sync into one wide word.
// A flush emits the partial word early, tagged with its valid lane count.
module fifo_stream_packer #(
  parameter int DataWidth = 4,
  parameter int Ratio     = 4,
  localparam int OutWidth = DataWidth * Ratio,
  localparam int CntWidth = $clog2(Ratio + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OutWidth-1:0] out_data_o,
  output logic [CntWidth-1:0] out_count_o
);

  typedef enum logic {ACCUM, FLUSH_WAIT} state_t;

  localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

  state_t              state;
  logic [OutWidth-1:0] acc;
  logic [CntWidth-1:0] cnt;
  logic [OutWidth-1:0] acc_w;
  logic [CntWidth-1:0] cnt_inc;
  logic                slot_free;
  logic                in_beat;

  // Accumulator with the incoming word dropped into lane cnt.
  for (genvar k = 0; k < Ratio; k++) begin : g_lane
    assign acc_w[k*DataWidth +: DataWidth] =
      (cnt == CntWidth'(k)) ? in_data_i : acc[k*DataWidth +: DataWidth];
  end

  assign cnt_inc   = cnt + CntWidth'(1);
  assign slot_free = !out_valid_o || out_ready_i;

  // The completing lane is only taken if the output register frees this edge.
  assign in_ready_o = reset_i && (state == ACCUM) &&
                      ((cnt < LastLane) || slot_free);
  assign in_beat    = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_count_o <= '0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        ACCUM: begin
          if (in_beat) begin
            if (cnt == LastLane || (flush_i && slot_free)) begin
              out_valid_o <= 1'b1;
              out_data_o  <= acc_w;
              out_count_o <= cnt_inc;
              acc         <= '0;
              cnt         <= '0;
            end else begin
              acc <= acc_w;
              cnt <= cnt_inc;
              if (flush_i) state <= FLUSH_WAIT;
            end
          end else if (flush_i && cnt != '0) begin
            if (slot_free) begin
              out_valid_o <= 1'b1;
              out_data_o  <= acc;
              out_count_o <= cnt;
              acc         <= '0;
              cnt         <= '0;
            end else begin
              state <= FLUSH_WAIT;
            end
          end
        end
        FLUSH_WAIT: begin
          if (slot_free) begin
            out_valid_o <= 1'b1;
            out_data_o  <= acc;
            out_count_o <= cnt;
            acc         <= '0;
            cnt         <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
